// File: rtl/ddr_readout.sv
// Reads a region of DDR over AXI4 in 512-bit beats and serializes each beat
// LSB-first into the SiTCP byte stream, one burst outstanding at a time.
module ddr_readout #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          BURST_LEN = 16
) (
    input  logic         axi_clk,
    input  logic         axi_aresetn,
    input  logic         start,
    input  logic [31:0]  data_number,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [31:0]  axi_araddr,
    output logic [7:0]   axi_arlen,
    output logic [2:0]   axi_arsize,
    output logic [1:0]   axi_arburst,
    output logic         axi_arvalid,
    input  logic         axi_arready,
    input  logic [511:0] axi_rdata,
    input  logic         axi_rlast,
    input  logic         axi_rvalid,
    output logic         axi_rready,
    output logic [7:0]   tcp_tx_data,
    output logic         tcp_tx_wr,
    input  logic         tcp_tx_full
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] DONE = 2'd3;
    localparam logic [31:0] BURST_MAX = 32'(BURST_LEN);

    logic [1:0]   state_reg;
    logic [31:0]  remaining_reg;
    logic [7:0]   burst_cnt_reg;
    logic [511:0] hold_reg;
    logic         hold_full_reg;
    logic [5:0]   byte_idx_reg;

    logic [31:0]  len_src;
    logic [7:0]   next_arlen;
    logic         beat;
    logic         byte_wr;

    // Length of the next burst comes from data_number at start, else from the beats left.
    assign len_src    = (state_reg == IDLE) ? data_number : remaining_reg;
    assign next_arlen = (len_src > BURST_MAX) ? 8'(BURST_MAX - 32'd1) : 8'(len_src - 32'd1);

    assign axi_arsize  = 3'b110;
    assign axi_arburst = 2'b01;
    assign axi_rready  = (state_reg == DATA) && !hold_full_reg && (burst_cnt_reg != 8'd0);
    assign beat        = axi_rvalid && axi_rready;

    // Write strobe is combinational so it can never coincide with tcp_tx_full.
    assign byte_wr     = hold_full_reg && !tcp_tx_full;
    assign tcp_tx_wr   = byte_wr;
    assign tcp_tx_data = hold_full_reg ? hold_reg[7:0] : 8'h00;

    // Data path only: the byte currently on offer always sits in the low byte.
    always_ff @(posedge axi_clk) begin
        if (beat) begin
            hold_reg <= axi_rdata;
        end else if (byte_wr) begin
            hold_reg <= hold_reg >> 8;
        end
    end

    always_ff @(posedge axi_clk) begin
        if (!axi_aresetn) begin
            state_reg     <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            axi_arvalid   <= 1'b0;
            axi_araddr    <= BASE_ADDR;
            axi_arlen     <= 8'd0;
            remaining_reg <= 32'd0;
            burst_cnt_reg <= 8'd0;
            hold_full_reg <= 1'b0;
            byte_idx_reg  <= 6'd0;
        end else begin
            done <= 1'b0;
            if (byte_wr) begin
                byte_idx_reg <= byte_idx_reg + 6'd1;
                if (byte_idx_reg == 6'd63) begin
                    hold_full_reg <= 1'b0;
                end
            end

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        busy          <= 1'b1;
                        err           <= 1'b0;
                        axi_araddr    <= BASE_ADDR;
                        remaining_reg <= data_number;
                        if (data_number == 32'd0) begin
                            state_reg <= DONE;
                        end else begin
                            axi_arlen   <= next_arlen;
                            axi_arvalid <= 1'b1;
                            state_reg   <= ADDR;
                        end
                    end
                end
                ADDR: begin
                    if (axi_arready) begin
                        axi_arvalid   <= 1'b0;
                        burst_cnt_reg <= axi_arlen + 8'd1;
                        axi_araddr    <= axi_araddr + (({24'd0, axi_arlen} + 32'd1) << 6);
                        state_reg     <= DATA;
                    end
                end
                DATA: begin
                    if (beat) begin
                        hold_full_reg <= 1'b1;
                        byte_idx_reg  <= 6'd0;
                        burst_cnt_reg <= burst_cnt_reg - 8'd1;
                        if (remaining_reg != 32'd0) begin
                            remaining_reg <= remaining_reg - 32'd1;
                        end
                        // Burst length is tracked by count; rlast is only cross-checked.
                        if (axi_rlast != (burst_cnt_reg == 8'd1)) begin
                            err <= 1'b1;
                        end
                    end else if (burst_cnt_reg == 8'd0) begin
                        if (remaining_reg != 32'd0) begin
                            axi_arlen   <= next_arlen;
                            axi_arvalid <= 1'b1;
                            state_reg   <= ADDR;
                        end else if (!hold_full_reg) begin
                            state_reg <= DONE;
                        end
                    end
                end
                default: begin
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_readout.sv
// Directed bench for ddr_readout: AXI read-slave model, byte scoreboard and
// a linear sequence of readout scenarios.
module tb_ddr_readout;

    localparam logic [31:0] BASE = 32'hFFFF_FC00;
    localparam int          BL   = 16;

    logic         axi_clk;
    logic         axi_aresetn;
    logic         start;
    logic [31:0]  data_number;
    logic         busy;
    logic         done;
    logic         err;
    logic [31:0]  axi_araddr;
    logic [7:0]   axi_arlen;
    logic [2:0]   axi_arsize;
    logic [1:0]   axi_arburst;
    logic         axi_arvalid;
    logic         axi_arready;
    logic [511:0] axi_rdata;
    logic         axi_rlast;
    logic         axi_rvalid;
    logic         axi_rready;
    logic [7:0]   tcp_tx_data;
    logic         tcp_tx_wr;
    logic         tcp_tx_full;

    int compared;
    int mismatched;
    int bytes_written;
    int arvalid_seen;
    int ar_delay;
    int rlast_beat;

    logic [7:0]  exp_bytes[$];
    logic [31:0] exp_addr[$];
    logic [7:0]  exp_len[$];

    ddr_readout #(.BASE_ADDR(BASE), .BURST_LEN(BL)) dut (
        .axi_clk(axi_clk), .axi_aresetn(axi_aresetn), .start(start),
        .data_number(data_number), .busy(busy), .done(done), .err(err),
        .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
        .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid),
        .axi_rready(axi_rready), .tcp_tx_data(tcp_tx_data), .tcp_tx_wr(tcp_tx_wr),
        .tcp_tx_full(tcp_tx_full)
    );

    initial begin
        axi_clk = 1'b0;
        forever #5 axi_clk = ~axi_clk;
    end

    function automatic logic [7:0] pat(input int k, input int j);
        return 8'(k * 7 + j);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_bytes(input int n);
        for (int k = 0; k < n; k++)
            for (int j = 0; j < 64; j++)
                exp_bytes.push_back(pat(k, j));
    endtask

    task automatic push_ar(input logic [31:0] addr, input logic [7:0] len);
        exp_addr.push_back(addr);
        exp_len.push_back(len);
    endtask

    task automatic do_start(input logic [31:0] n);
        @(posedge axi_clk); #1;
        start = 1'b1;
        data_number = n;
        @(posedge axi_clk); #1;
        start = 1'b0;
        data_number = 32'hDEAD_BEEF;
    endtask

    task automatic wait_done(input int budget);
        int  cyc;
        logic got;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < budget) begin
            @(negedge axi_clk);
            cyc++;
            if (done) got = 1'b1;
        end
        chk("done_seen", 32'(got), 32'd1);
        $display("readout finished after %0d cycles", cyc);
    endtask

    // AXI read slave: reacts on the falling edge to values that were stable at the rising edge.
    initial begin : slave
        int beats_left, beat_no, beat_glob, ar_wait;
        logic arvalid_s, rready_s, hs;
        logic [31:0] araddr_s;
        logic [7:0]  arlen_s;
        beats_left = 0; beat_no = 0; beat_glob = 0; ar_wait = 0;
        arvalid_s = 1'b0; rready_s = 1'b0; araddr_s = '0; arlen_s = '0;
        axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_rdata = '0;
        forever begin
            @(negedge axi_clk);
            if (!axi_aresetn) begin
                beats_left = 0; beat_no = 0; beat_glob = 0; ar_wait = 0;
                axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rlast = 1'b0;
            end else begin
                if (start && !busy) beat_glob = 0;
                hs = axi_arready && arvalid_s;
                if (hs) begin
                    chk("single_outstanding", 32'(beats_left), 32'd0);
                    if (exp_addr.size() == 0) begin
                        chk("ar_unexpected", 32'd1, 32'd0);
                    end else begin
                        chk("araddr", araddr_s, exp_addr.pop_front());
                        chk("arlen", 32'(arlen_s), 32'(exp_len.pop_front()));
                    end
                    $display("AR addr=%h len=%0d", araddr_s, arlen_s);
                    beats_left = int'(arlen_s) + 1;
                    beat_no = 0;
                end else if (axi_arvalid && arvalid_s) begin
                    chk("araddr_hold", axi_araddr, araddr_s);
                    chk("arlen_hold", 32'(axi_arlen), 32'(arlen_s));
                end
                if (axi_rvalid && rready_s) begin
                    beats_left--;
                    beat_no++;
                    beat_glob++;
                end
                ar_wait = axi_arvalid ? ar_wait + 1 : 0;
                axi_arready = axi_arvalid && (ar_wait > ar_delay);
                if (beats_left > 0) begin
                    axi_rvalid = 1'b1;
                    for (int j = 0; j < 64; j++) axi_rdata[j*8 +: 8] = pat(beat_glob, j);
                    axi_rlast = (rlast_beat >= 0) ? (beat_no == rlast_beat) : (beats_left == 1);
                end else begin
                    axi_rvalid = 1'b0;
                    axi_rlast = 1'b0;
                end
            end
            arvalid_s = axi_arvalid;
            araddr_s  = axi_araddr;
            arlen_s   = axi_arlen;
            rready_s  = axi_rready;
        end
    end

    // Byte scoreboard: every write pops one expected byte.
    initial begin : monitor
        forever begin
            @(negedge axi_clk);
            if (axi_aresetn) begin
                if (axi_arvalid) arvalid_seen++;
                if (tcp_tx_full) chk("wr_while_full", 32'(tcp_tx_wr), 32'd0);
                if (tcp_tx_wr) begin
                    bytes_written++;
                    if (exp_bytes.size() == 0) chk("byte_unexpected", 32'd1, 32'd0);
                    else chk("tx_byte", 32'(tcp_tx_data), 32'(exp_bytes.pop_front()));
                end
            end
        end
    end

    initial begin : stim
        int t0, t1, a0, cyc;
        compared = 0; mismatched = 0; bytes_written = 0; arvalid_seen = 0;
        ar_delay = 0; rlast_beat = -1;
        axi_aresetn = 1'b0; start = 1'b0; data_number = 32'd0; tcp_tx_full = 1'b0;

        repeat (3) @(posedge axi_clk);
        @(negedge axi_clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_arvalid", 32'(axi_arvalid), 32'd0);
        chk("rst_rready", 32'(axi_rready), 32'd0);
        chk("rst_araddr", axi_araddr, BASE);
        chk("rst_arlen", 32'(axi_arlen), 32'd0);
        chk("rst_tx_wr", 32'(tcp_tx_wr), 32'd0);
        chk("arsize", 32'(axi_arsize), 32'd6);
        chk("arburst", 32'(axi_arburst), 32'd1);
        @(posedge axi_clk); #1;
        axi_aresetn = 1'b1;

        // Zero-length readout: done within 2 cycles, no traffic.
        t0 = bytes_written; a0 = arvalid_seen;
        do_start(32'd0);
        wait_done(2);
        chk("zero_busy_after", 32'(busy), 32'd0);
        repeat (3) @(negedge axi_clk);
        chk("zero_no_arvalid", 32'(arvalid_seen - a0), 32'd0);
        chk("zero_no_write", 32'(bytes_written - t0), 32'd0);

        // Single beat: bytes 00..3F.
        push_ar(BASE, 8'd0); push_bytes(1);
        t0 = bytes_written;
        do_start(32'd1);
        @(negedge axi_clk);
        chk("one_busy", 32'(busy), 32'd1);
        wait_done(500);
        chk("one_busy_after", 32'(busy), 32'd0);
        chk("one_bytes", 32'(bytes_written - t0), 32'd64);
        chk("one_queue_empty", 32'(exp_bytes.size()), 32'd0);
        @(negedge axi_clk);
        chk("done_one_cycle", 32'(done), 32'd0);

        // Two bursts (16+4), address wraps past 2^32, slow arready, start while busy ignored.
        ar_delay = 3;
        push_ar(BASE, 8'd15); push_ar(BASE + 32'd1024, 8'd3); push_bytes(20);
        t0 = bytes_written;
        do_start(32'd20);
        repeat (5) @(posedge axi_clk);
        #1; start = 1'b1; data_number = 32'd5;
        @(posedge axi_clk); #1; start = 1'b0;
        wait_done(5000);
        chk("twenty_bytes", 32'(bytes_written - t0), 32'd1280);
        chk("twenty_queue_empty", 32'(exp_bytes.size()), 32'd0);
        chk("twenty_ar_empty", 32'(exp_addr.size()), 32'd0);
        ar_delay = 0;

        // Back-pressure for 10 cycles after byte 20 of the first beat.
        push_ar(BASE, 8'd1); push_bytes(2);
        t0 = bytes_written;
        do_start(32'd2);
        cyc = 0;
        while ((bytes_written - t0) < 21 && cyc < 1000) begin
            @(posedge axi_clk); #1;
            cyc++;
        end
        chk("stall_reach", 32'(bytes_written - t0), 32'd21);
        tcp_tx_full = 1'b1;
        t1 = bytes_written;
        for (int i = 0; i < 10; i++) begin
            @(posedge axi_clk); #1;
            chk("stall_rready", 32'(axi_rready), 32'd0);
        end
        chk("stall_no_write", 32'(bytes_written - t1), 32'd0);
        tcp_tx_full = 1'b0;
        wait_done(1000);
        chk("stall_bytes", 32'(bytes_written - t0), 32'd128);
        chk("stall_queue_empty", 32'(exp_bytes.size()), 32'd0);

        // Early rlast on beat 3: err set, all 16 beats consumed, cleared by next start.
        rlast_beat = 2;
        push_ar(BASE, 8'd15); push_bytes(16);
        t0 = bytes_written;
        do_start(32'd16);
        wait_done(3000);
        chk("rlast_err", 32'(err), 32'd1);
        chk("rlast_bytes", 32'(bytes_written - t0), 32'd1024);
        chk("rlast_queue_empty", 32'(exp_bytes.size()), 32'd0);
        rlast_beat = -1;
        push_ar(BASE, 8'd0); push_bytes(1);
        do_start(32'd1);
        @(negedge axi_clk);
        chk("err_cleared", 32'(err), 32'd0);
        wait_done(500);
        chk("err_stays_clear", 32'(err), 32'd0);

        // Reset during beat 5 of a 16-beat burst.
        push_ar(BASE, 8'd15); push_bytes(16);
        t0 = bytes_written;
        do_start(32'd16);
        cyc = 0;
        while ((bytes_written - t0) < (4 * 64 + 10) && cyc < 2000) begin
            @(posedge axi_clk); #1;
            cyc++;
        end
        chk("midreset_reach", 32'(bytes_written - t0), 32'(4 * 64 + 10));
        axi_aresetn = 1'b0;
        @(posedge axi_clk);
        @(negedge axi_clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        chk("midrst_arvalid", 32'(axi_arvalid), 32'd0);
        chk("midrst_rready", 32'(axi_rready), 32'd0);
        chk("midrst_tx_wr", 32'(tcp_tx_wr), 32'd0);
        chk("midrst_tx_data", 32'(tcp_tx_data), 32'd0);
        chk("midrst_araddr", axi_araddr, BASE);
        chk("midrst_arlen", 32'(axi_arlen), 32'd0);
        exp_bytes.delete(); exp_addr.delete(); exp_len.delete();
        t1 = bytes_written;
        repeat (3) @(posedge axi_clk);
        #1; axi_aresetn = 1'b1;
        repeat (4) @(negedge axi_clk);
        chk("midrst_no_write", 32'(bytes_written - t1), 32'd0);
        push_ar(BASE, 8'd0); push_bytes(1);
        do_start(32'd1);
        wait_done(500);
        chk("after_rst_queue_empty", 32'(exp_bytes.size()), 32'd0);
        chk("after_rst_ar_empty", 32'(exp_addr.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ddr_readout.md
DDR_READOUT -- requirements
Module: ddr_readout

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, start address of the captured region; SHALL be 1024-byte aligned.
REQ-002 SHALL have parameter BURST_LEN, default 16, maximum beats per AXI read burst; legal values are 1-16.
REQ-003 SHALL have port axi_clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port axi_aresetn, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port start, input, 1, one-cycle request to begin a readout.
REQ-006 SHALL have port data_number, input, 32, number of 512-bit beats to read; sampled only when start is accepted.
REQ-007 SHALL have port busy, input-independent output, 1, high from an accepted start until done.
REQ-008 SHALL have port done, output, 1, one-cycle pulse when the readout finishes.
REQ-009 SHALL have port err, output, 1, sticky flag for an rlast mismatch; cleared by reset or an accepted start.
REQ-010 SHALL have AXI4 read-master ports with the following widths: axi_araddr out 32, axi_arlen out 8, axi_arsize out 3, axi_arburst out 2, axi_arvalid out 1, axi_arready in 1, axi_rdata in 512, axi_rlast in 1, axi_rvalid in 1, axi_rready out 1.
REQ-011 SHALL have ports tcp_tx_data, output, 8, and tcp_tx_wr, output, 1, which form the byte stream to the SiTCP TCP transmit path.
REQ-012 SHALL have port tcp_tx_full, input, 1, back-pressure from SiTCP.

Function
REQ-013 SHALL drive axi_arsize as the constant 3'b110 (64 bytes) and axi_arburst as the constant 2'b01 (INCR).
REQ-014 SHALL implement FSM states IDLE, ADDR, DATA and DONE.
REQ-015 IDLE SHALL go to ADDR on start; if data_number is 0 it SHALL go directly to DONE, and no AXI traffic SHALL occur.
REQ-016 SHALL ignore start while busy is high.
REQ-017 ADDR SHALL behave as follows:
- drive axi_arvalid high;
- drive axi_arlen as min(BURST_LEN, remaining) minus 1;
- hold axi_araddr and axi_arlen stable until axi_arready is high;
- on the handshake, go to DATA.
REQ-018 The first burst address SHALL be BASE_ADDR; each following burst address SHALL be the previous address plus 64 times (arlen+1), with 32-bit wrap.
REQ-019 At most one read burst SHALL be outstanding at any time.
REQ-020 A single 512-bit holding register SHALL be provided, and axi_rready SHALL be high only in DATA while the holding register is empty.
REQ-021 On an rvalid&rready beat, the holding register SHALL load rdata, and the remaining-beat and burst-beat counters SHALL decrement.
REQ-022 The serializer SHALL emit the held beat as 64 bytes, least-significant byte first (rdata[7:0] first, then rdata[511:504] last), at one byte per cycle whenever tcp_tx_full is low.
REQ-023 tcp_tx_wr SHALL be low in every cycle in which tcp_tx_full is high; no byte SHALL be dropped or duplicated.
REQ-024 The holding register SHALL become empty in the cycle after its 64th byte is written; rready MAY then reassert.
REQ-025 The burst SHALL end on the burst-beat count reaching zero, not on rlast.
REQ-026 err SHALL be set if rlast disagrees with the final-beat position of the burst.
REQ-027 After the last beat of a burst, the FSM SHALL go to ADDR if beats remain; otherwise it SHALL go to DONE once the holding register has drained.
REQ-028 DONE SHALL pulse done for 1 cycle, deassert busy, and go to IDLE.
REQ-029 The beat counter SHALL be 32 bits and SHALL never underflow.

Reset
REQ-030 When axi_aresetn is low at a rising edge of axi_clk, the block SHALL apply the following:
- FSM returns to IDLE;
- busy, done, err, axi_arvalid, axi_rready and tcp_tx_wr become 0;
- axi_araddr becomes BASE_ADDR;
- axi_arlen and tcp_tx_data become 0;
- the holding register is marked empty.
REQ-031 A reset applied mid-burst SHALL abandon the burst immediately, with no further writes.

Verification
REQ-032 start with data_number=0 -> done pulses within 2 cycles; axi_arvalid never asserts; tcp_tx_wr never asserts.
REQ-033 data_number=1, arready and rvalid immediate, rdata={64 bytes 8'h3F..8'h00} -> araddr=BASE_ADDR and arlen=0; 64 writes in the order 00,01,...,3F; then done.
REQ-034 data_number=20, BURST_LEN=16 -> first burst araddr=BASE_ADDR with arlen=15; second burst araddr=BASE_ADDR+1024 with arlen=3; exactly 1280 bytes written.
REQ-035 tcp_tx_full high for 10 cycles after byte 20 of a beat -> no tcp_tx_wr for those cycles; rready stays low; byte 21 is emitted after release with no gap or duplicate.
REQ-036 axi_aresetn low during beat 5 of a 16-beat burst -> all outputs take their REQ-030 values on the next edge; a new start afterwards reissues araddr=BASE_ADDR.
REQ-037 rlast asserted on beat 3 of an arlen=15 burst -> err=1; all 16 beats are still consumed; err clears on the next start.
